inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction fetch stage ahead of the decoder. Fetches 64-bit instructions as two 32-bit words over a req/ack
//  instruction-memory port and presents {pc, inst} to IF/ID through a 1-entry output register.
//  Consumes the decoder's branch_flag/target_addr with one architectural delay slot.
//  PC advances by 8 per instruction; the delay slot is the instruction at branch_pc+8.
// PARAMETERS
//  RESET_PC  32'h0000_0000  address of first instruction fetched after reset (8-byte aligned)
// PORTS
//  clk             in   1   clock, all state updates on rising edge
//  rst             in   1   reset, synchronous, active-high
//  stall_i         in   1   from ctrl; 1 = IF/ID does not accept this cycle
//  branch_flag_i   in   1   decoder: instruction in ID takes a branch
//  target_addr_i   in   32  decoder: branch target (8-byte aligned)
//  mem_req_o       out  1   instruction-memory read request
//  mem_addr_o      out  32  word address of request
//  mem_ack_i       in   1   read data valid, completes request
//  mem_rdata_i     in   32  read data
//  inst_valid_o    out  1   output register holds an instruction
//  pc_o            out  32  address of inst_o
//  inst_o          out  64  instruction: [63:32] from pc_o, [31:0] from pc_o+4
// BEHAVIOUR
//  Reset: inst_valid_o=0, pc_o=0, inst_o=0, mem_req_o=0, mem_addr_o=0, fetch_pc=RESET_PC, state=S_HI,
//   redirect_pend=0, discard=0. Reset mid-request abandons it; a late ack after reset is ignored.
//  Accept: output consumed when inst_valid_o && !stall_i. Branch accepted when branch_flag_i && !stall_i.
//  FSM (fetch_pc = instruction being assembled):
//   S_HI : req=1, addr=fetch_pc. On ack: hi_buf<=rdata -> S_LO.
//   S_LO : req=1, addr=fetch_pc+4. On ack: if slot free or consumed this cycle, load out reg
//          {pc_o=fetch_pc, inst_o={hi_buf,rdata}, valid=1}, advance fetch_pc, -> S_HI; else lo_buf<=rdata -> S_WAIT.
//   S_WAIT: req=0. When slot free/consumed: load out reg from {hi_buf,lo_buf}, advance fetch_pc, -> S_HI.
//  Handshake: once req=1, addr stays constant until ack (no abort); S_HI->S_LO->S_HI chain gives
//   best-case throughput one instruction per 2 cycles; req drops only in S_WAIT and reset.
//  Advance: fetch_pc <= redirect_pend ? target_q : fetch_pc+8; redirect_pend cleared on use. Adder wraps mod 2^32.
//  Out reg with no load and consumed this cycle -> inst_valid_o=0; unconsumed -> holds all fields.
//  Branch acceptance, case A (inst_valid_o=1): out reg is the delay slot (moving to IF/ID this cycle).
//   The instruction in fetch is wrong-path: set discard=1, target_q<=target_addr_i.
//   Outstanding beat still completes on bus; its data is dropped. On that ack (including the same cycle
//   as acceptance) or immediately in S_WAIT: fetch_pc<=target_q, -> S_HI, discard=0, no out-reg load.
//  Case B (inst_valid_o=0): instruction in fetch is the delay slot; completes normally;
//   redirect_pend=1, target_q<=target_addr_i; the instruction after it comes from the target.
//  Branch while redirect_pend/discard set: newest target overwrites target_q.
//  branch_flag_i with stall_i=1: ignored (decoder re-asserts).
//  Addresses never checked for alignment; low 3 bits of target passed through.
// TESTING
//  1 Reset, ack every cycle, stall_i=0, RESET_PC=0 -> mem_addr 0,4,8,C..; pc_o 0,8,10 every 2 cycles;
//    inst_o={word@0,word@4}.
//  2 Hold stall_i=1 for 5 cycles with valid out -> pc_o/inst_o stable, FSM stops in S_WAIT with req=0;
//    release -> next pc_o appears next cycle.
//  3 Branch at pc 0x10 with out valid (pc 0x18), target 0x100 -> IF/ID gets 0x18 then 0x100;
//    in-flight fetch of 0x20 completes on bus but is never presented.
//  4 Branch with out empty, ack delayed 3 cycles on both beats -> delay slot 0x18 presented, then 0x100.
//  5 Case A branch in same cycle as S_HI ack -> that word discarded, next mem_addr=0x100.
//  6 rst asserted while req pending, ack arrives next cycle -> all outputs reset values; first post-reset
//    mem_addr=RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - two-beat 64-bit instruction fetch with one delay slot and 1-entry IF/ID output register
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] target_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic [63:0] inst_o
);

  typedef enum logic [1:0] {S_HI, S_LO, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] hi_buf_q, hi_buf_d;
  logic [31:0] lo_buf_q, lo_buf_d;
  logic [31:0] target_q, target_d;
  logic        redirect_pend_q, redirect_pend_d;
  logic        discard_q, discard_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [63:0] inst_q, inst_d;

  logic        consumed, slot_free, br_acc, case_a, case_b;
  logic        disc, pend, redirect, advance;
  logic [31:0] tgt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_HI;
      fetch_pc_q      <= RESET_PC;
      hi_buf_q        <= 32'h0;
      lo_buf_q        <= 32'h0;
      target_q        <= 32'h0;
      redirect_pend_q <= 1'b0;
      discard_q       <= 1'b0;
      valid_q         <= 1'b0;
      pc_q            <= 32'h0;
      inst_q          <= 64'h0;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      hi_buf_q        <= hi_buf_d;
      lo_buf_q        <= lo_buf_d;
      target_q        <= target_d;
      redirect_pend_q <= redirect_pend_d;
      discard_q       <= discard_d;
      valid_q         <= valid_d;
      pc_q            <= pc_d;
      inst_q          <= inst_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    hi_buf_d        = hi_buf_q;
    lo_buf_d        = lo_buf_q;
    target_d        = target_q;
    redirect_pend_d = redirect_pend_q;
    discard_d       = discard_q;
    valid_d         = valid_q;
    pc_d            = pc_q;
    inst_d          = inst_q;
    redirect        = 1'b0;
    advance         = 1'b0;

    consumed  = valid_q && !stall_i;
    slot_free = !valid_q || consumed;
    br_acc    = branch_flag_i && !stall_i;
    case_a    = br_acc && valid_q;
    case_b    = br_acc && !valid_q;
    // A branch accepted this cycle acts immediately, so same-cycle acks see it.
    tgt       = br_acc ? target_addr_i : target_q;
    disc      = discard_q || case_a;
    pend      = redirect_pend_q || case_b;

    if (consumed) valid_d = 1'b0;

    case (state_q)
      S_HI: begin
        if (mem_ack_i) begin
          if (disc) begin
            redirect = 1'b1;
          end else begin
            hi_buf_d = mem_rdata_i;
            state_d  = S_LO;
          end
        end
      end
      S_LO: begin
        if (mem_ack_i) begin
          if (disc) begin
            redirect = 1'b1;
          end else if (slot_free) begin
            advance = 1'b1;
            inst_d  = {hi_buf_q, mem_rdata_i};
          end else begin
            lo_buf_d = mem_rdata_i;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (disc) begin
          redirect = 1'b1;
        end else if (slot_free) begin
          advance = 1'b1;
          inst_d  = {hi_buf_q, lo_buf_q};
        end
      end
      default: state_d = S_HI;
    endcase

    target_d        = tgt;
    discard_d       = disc;
    redirect_pend_d = pend;

    // Wrong-path beat has completed: drop it and restart at the target.
    if (redirect) begin
      fetch_pc_d      = tgt;
      state_d         = S_HI;
      discard_d       = 1'b0;
      redirect_pend_d = 1'b0;
    end

    if (advance) begin
      valid_d         = 1'b1;
      pc_d            = fetch_pc_q;
      fetch_pc_d      = pend ? tgt : fetch_pc_q + 32'd8;
      redirect_pend_d = 1'b0;
      state_d         = S_HI;
    end
  end

  assign mem_req_o    = !rst && (state_q != S_WAIT);
  assign mem_addr_o   = rst ? 32'h0 : ((state_q == S_LO) ? fetch_pc_q + 32'd4 : fetch_pc_q);
  assign inst_valid_o = valid_q;
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch: IF/ID output queue and acked-address queue
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] target_addr_i = 32'h0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        inst_valid_o;
  logic [31:0] pc_o;
  logic [63:0] inst_o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_addr_q[$];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic        late_ack = 1'b0;
  logic [31:0] mon_pc;
  logic [31:0] mon_addr;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .branch_flag_i (branch_flag_i),
    .target_addr_i (target_addr_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .pc_o          (pc_o),
    .inst_o        (inst_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory: acks after ack_delay idle request cycles; every ack is checked against the address queue.
  always @(negedge clk) begin
    mem_ack_i = 1'b0;
    if (late_ack) begin
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hDEAD_BEEF;
      wait_cnt    = 0;
    end else if (!rst && mem_req_o) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = word_at(mem_addr_o);
        wait_cnt    = 0;
        if (exp_addr_q.size() > 0) begin
          mon_addr = exp_addr_q.pop_front();
          check("mem_addr", 128'(mem_addr_o), 128'(mon_addr));
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // IF/ID monitor: every consumed instruction is checked against the expected pc queue.
  always @(negedge clk) begin
    if (!rst && inst_valid_o && !stall_i && exp_pc_q.size() > 0) begin
      mon_pc = exp_pc_q.pop_front();
      check("if_id_out", {32'h0, pc_o, inst_o}, {32'h0, mon_pc, word_at(mon_pc), word_at(mon_pc + 32'd4)});
    end
  end

  task automatic push_addrs(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_addr_q.push_back(start + 32'(4 * i));
  endtask

  task automatic push_pcs(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_pc_q.push_back(start + 32'(8 * i));
  endtask

  task automatic do_reset(input logic with_late_ack);
    @(posedge clk);
    #1;
    exp_pc_q.delete();
    exp_addr_q.delete();
    rst      = 1'b1;
    late_ack = with_late_ack;
    @(posedge clk);
    #1 late_ack = 1'b0;
    @(negedge clk);
    check("rst_valid", 128'(inst_valid_o), 128'(0));
    check("rst_pc",    128'(pc_o),         128'(0));
    check("rst_inst",  128'(inst_o),       128'(0));
    check("rst_req",   128'(mem_req_o),    128'(0));
    check("rst_addr",  128'(mem_addr_o),   128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_pc_q.size() != 0 || exp_addr_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 128'(exp_pc_q.size() + exp_addr_q.size()), 128'(0));
  endtask

  // Raise branch_flag_i for one cycle once pc_o==at_pc is valid: in that same cycle (now=1) or the next.
  task automatic branch_when(input logic [31:0] at_pc, input logic now, input logic [31:0] tgt);
    int n = 0;
    @(negedge clk);
    while (!(inst_valid_o && pc_o == at_pc) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("branch_trigger_seen", 128'(n < 300), 128'(1));
    if (!now) begin
      @(posedge clk);
      #1;
    end
    branch_flag_i = 1'b1;
    target_addr_i = tgt;
    @(posedge clk);
    #1 branch_flag_i = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1 + 2: straight-line fetch, then a long stall with the output held.
    ack_delay = 0;
    do_reset(1'b0);
    push_addrs(32'h0, 10);
    push_pcs(32'h0, 5);
    @(negedge clk);
    check("t1_c0_valid", 128'(inst_valid_o), 128'(0));
    check("t1_c0_addr",  {95'h0, mem_req_o, mem_addr_o}, {95'h0, 1'b1, 32'h0});
    @(negedge clk);
    @(negedge clk);
    check("t1_c2_out", {95'h0, inst_valid_o, pc_o}, {95'h0, 1'b1, 32'h0});
    @(negedge clk);
    check("t1_c3_valid", 128'(inst_valid_o), 128'(0));
    @(negedge clk);
    check("t1_c4_out", {95'h0, inst_valid_o, pc_o}, {95'h0, 1'b1, 32'h8});
    @(posedge clk);
    #1 stall_i = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_stall_hold", {31'h0, inst_valid_o, pc_o, inst_o},
            {31'h0, 1'b1, 32'h10, word_at(32'h10), word_at(32'h14)});
    end
    check("t2_wait_req", 128'(mem_req_o), 128'(0));
    @(posedge clk);
    #1 stall_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t2_release_next", {95'h0, inst_valid_o, pc_o}, {95'h0, 1'b1, 32'h18});
    wait_drain("t1_drain");

    // Test 3: case A with the wrong-path S_HI beat still waiting for its ack.
    ack_delay = 1;
    do_reset(1'b0);
    push_addrs(32'h0, 9);
    push_addrs(32'h100, 4);
    push_pcs(32'h0, 4);
    push_pcs(32'h100, 2);
    branch_when(32'h18, 1'b1, 32'h100);
    wait_drain("t3_drain");

    // Test 4: case B with an empty output register and slow memory.
    ack_delay = 3;
    do_reset(1'b0);
    push_addrs(32'h0, 8);
    push_addrs(32'h100, 4);
    push_pcs(32'h0, 4);
    push_pcs(32'h100, 2);
    branch_when(32'h10, 1'b0, 32'h100);
    wait_drain("t4_drain");

    // Test 5: case A in the same cycle as the wrong-path S_HI ack.
    ack_delay = 0;
    do_reset(1'b0);
    push_addrs(32'h0, 9);
    push_addrs(32'h100, 4);
    push_pcs(32'h0, 4);
    push_pcs(32'h100, 2);
    branch_when(32'h18, 1'b1, 32'h100);
    wait_drain("t5_drain");

    // Test 6: reset during a pending request, with a stray ack while reset is high.
    ack_delay = 3;
    repeat (2) @(negedge clk);
    check("t6_req_pending", 128'(mem_req_o), 128'(1));
    ack_delay = 0;
    do_reset(1'b1);
    push_addrs(32'h0, 4);
    push_pcs(32'h0, 2);
    @(negedge clk);
    check("t6_first_addr", {95'h0, mem_req_o, mem_addr_o}, {95'h0, 1'b1, 32'h0});
    wait_drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
